// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MIPS32 MEM-stage unit.
//   - Access size encodings carried on EX_MEM_Size (11 behaves as a word).
//   - Stall FSM state type.
//   - byte_enable(): store byte-lane enables from size and address low bits.
package mem_stage_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: be = 4'b0001 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_unit_lane.sv
// mem_lane_align: combinational byte/half lane logic for data-memory accesses.
// Ports:
//   addr_lo     in  2   effective address bits [1:0]
//   size        in  2   access size (SZ_WORD / SZ_HALF / SZ_BYTE, 11 = word)
//   is_unsigned in  1   zero-extend sub-word loads
//   raw_word    in  32  store data (store path) or memory read word (load path)
//   be          out 4   store byte enables
//   wdata_rep   out 32  store data replicated across lanes
//   rdata_ext   out 32  selected load lane, sign/zero extended
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw_word,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = raw_word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    be     = byte_enable(size, addr_lo);
    case (size)
      SZ_BYTE: begin
        wdata_rep = {4{raw_word[7:0]}};
        rdata_ext = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        wdata_rep = {2{raw_word[15:0]}};
        rdata_ext = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      default: begin
        wdata_rep = raw_word;
        rdata_ext = raw_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MIPS32 MEM stage. Routes loads/stores to the external data
// memory or to NUM_BUF internal word buffers, aligns sub-word accesses and
// stalls the pipeline while a multi-cycle memory read is outstanding.
// Ports:
//   Clk, Reset                 clock (rising edge), async active-high reset
//   EX_MEM_Valid/MemRead/MemWrite/Size/Unsigned/BufSel/ALUResult/rt_val
//                              operation from the EX/MEM register
//   MEM_ReadData, MEM_ReadValid registered load result and 1-cycle valid
//   MEM_Stall                  combinational hold for EX/MEM and upstream
//   MEM_Misaligned             registered 1-cycle alignment fault pulse
//   dmem_addr/wdata/be/we/re   data-memory request, dmem_rdata read data
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_BUF     = 2,
  parameter int BUF_DEPTH   = 8,
  parameter int MEM_LATENCY = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               EX_MEM_Valid,
  input  logic               EX_MEM_MemRead,
  input  logic               EX_MEM_MemWrite,
  input  logic [1:0]         EX_MEM_Size,
  input  logic               EX_MEM_Unsigned,
  input  logic [NUM_BUF-1:0] EX_MEM_BufSel,
  input  logic [ADDR_W-1:0]  EX_MEM_ALUResult,
  input  logic [DATA_W-1:0]  EX_MEM_rt_val,
  output logic [DATA_W-1:0]  MEM_ReadData,
  output logic               MEM_ReadValid,
  output logic               MEM_Stall,
  output logic               MEM_Misaligned,
  output logic [ADDR_W-1:0]  dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic [3:0]         dmem_be,
  output logic               dmem_we,
  output logic               dmem_re,
  input  logic [DATA_W-1:0]  dmem_rdata
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int CH_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic               uns_q;

  logic               in_wait;
  logic               accept, buf_hit, is_store, is_load, mis_addr;
  logic               misaligned, buf_store, buf_load, mem_store, mem_load;
  logic [CH_W-1:0]    buf_ch;
  logic [IDX_W-1:0]   buf_idx;
  logic [DATA_W-1:0]  buf_rdata;
  logic [DATA_W-1:0]  bufs [NUM_BUF][BUF_DEPTH];

  logic [1:0]         lane_addr, lane_size;
  logic               lane_uns;
  logic [31:0]        lane_raw, lane_wdata, lane_rdata;
  logic [3:0]         lane_be;

  // Operation decode; only meaningful while idle.
  always_comb begin
    buf_ch = '0;
    // Scan downwards so the lowest selected channel is assigned last.
    for (int unsigned i = NUM_BUF; i > 0; i--) begin
      if (EX_MEM_BufSel[i-1]) buf_ch = CH_W'(i - 1);
    end
    buf_idx  = EX_MEM_ALUResult[IDX_W-1:0];
    buf_hit  = |EX_MEM_BufSel;
    in_wait  = (state == ST_WAIT);
    accept   = EX_MEM_Valid && (state == ST_IDLE);
    is_store = EX_MEM_MemWrite;
    is_load  = EX_MEM_MemRead && !EX_MEM_MemWrite;
    case (EX_MEM_Size)
      SZ_HALF: mis_addr = EX_MEM_ALUResult[0];
      SZ_BYTE: mis_addr = 1'b0;
      default: mis_addr = (EX_MEM_ALUResult[1:0] != 2'b00);
    endcase
    misaligned = accept && !buf_hit && (is_store || is_load) && mis_addr;
    buf_store  = accept && buf_hit && is_store;
    buf_load   = accept && buf_hit && is_load;
    mem_store  = accept && !buf_hit && is_store && !mis_addr;
    mem_load   = accept && !buf_hit && is_load && !mis_addr;
  end

  assign buf_rdata = bufs[buf_ch][buf_idx];

  // One aligner serves both directions: the store path in IDLE, the read
  // capture in WAIT using the attributes latched at accept.
  always_comb begin
    lane_addr = in_wait ? addr_q[1:0] : EX_MEM_ALUResult[1:0];
    lane_size = in_wait ? size_q : EX_MEM_Size;
    lane_uns  = in_wait ? uns_q : EX_MEM_Unsigned;
    lane_raw  = in_wait ? dmem_rdata : EX_MEM_rt_val;
  end

  mem_lane_align u_lane (
    .addr_lo     (lane_addr),
    .size        (lane_size),
    .is_unsigned (lane_uns),
    .raw_word    (lane_raw),
    .be          (lane_be),
    .wdata_rep   (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

  // Request outputs and stall are combinational, so they are gated by the
  // asynchronous reset to drop immediately rather than at the next edge.
  always_comb begin
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    dmem_we    = 1'b0;
    dmem_re    = 1'b0;
    if (!Reset) begin
      if (mem_store) begin
        dmem_addr  = EX_MEM_ALUResult;
        dmem_wdata = lane_wdata;
        dmem_be    = lane_be;
        dmem_we    = 1'b1;
      end else if (mem_load) begin
        dmem_addr = EX_MEM_ALUResult;
        dmem_re   = 1'b1;
      end else if (in_wait) begin
        dmem_addr = addr_q;
      end
    end
  end

  assign MEM_Stall = !Reset && (mem_load || (in_wait && (cnt != '0)));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      MEM_ReadData   <= '0;
      MEM_ReadValid  <= 1'b0;
      MEM_Misaligned <= 1'b0;
    end else begin
      MEM_ReadValid  <= 1'b0;
      MEM_Misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (misaligned) begin
            MEM_Misaligned <= 1'b1;
          end else if (buf_load) begin
            MEM_ReadData  <= buf_rdata;
            MEM_ReadValid <= 1'b1;
          end else if (mem_load) begin
            state  <= ST_WAIT;
            cnt    <= CNT_LOAD;
            addr_q <= EX_MEM_ALUResult;
            size_q <= EX_MEM_Size;
            uns_q  <= EX_MEM_Unsigned;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            MEM_ReadData  <= lane_rdata;
            MEM_ReadValid <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned c = 0; c < NUM_BUF; c++) begin
        for (int unsigned w = 0; w < BUF_DEPTH; w++) begin
          bufs[CH_W'(c)][IDX_W'(w)] <= '0;
        end
      end
    end else if (buf_store) begin
      bufs[buf_ch][buf_idx] <= EX_MEM_rt_val;
    end
  end

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb_mem_stage_unit: directed self-checking bench for mem_stage_unit with a
// three-cycle data-memory latency. Inputs change just after the rising edge;
// outputs are sampled on the falling edge.
module tb_mem_stage_unit;
  import mem_stage_pkg::*;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int NUM_BUF     = 2;
  localparam int BUF_DEPTH   = 8;
  localparam int MEM_LATENCY = 3;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               EX_MEM_Valid, EX_MEM_MemRead, EX_MEM_MemWrite;
  logic [1:0]         EX_MEM_Size;
  logic               EX_MEM_Unsigned;
  logic [NUM_BUF-1:0] EX_MEM_BufSel;
  logic [ADDR_W-1:0]  EX_MEM_ALUResult;
  logic [DATA_W-1:0]  EX_MEM_rt_val;
  logic [DATA_W-1:0]  MEM_ReadData;
  logic               MEM_ReadValid, MEM_Stall, MEM_Misaligned;
  logic [ADDR_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [3:0]         dmem_be;
  logic               dmem_we, dmem_re;
  logic [DATA_W-1:0]  dmem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  mem_stage_unit #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .NUM_BUF     (NUM_BUF),
    .BUF_DEPTH   (BUF_DEPTH),
    .MEM_LATENCY (MEM_LATENCY)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .EX_MEM_Valid     (EX_MEM_Valid),
    .EX_MEM_MemRead   (EX_MEM_MemRead),
    .EX_MEM_MemWrite  (EX_MEM_MemWrite),
    .EX_MEM_Size      (EX_MEM_Size),
    .EX_MEM_Unsigned  (EX_MEM_Unsigned),
    .EX_MEM_BufSel    (EX_MEM_BufSel),
    .EX_MEM_ALUResult (EX_MEM_ALUResult),
    .EX_MEM_rt_val    (EX_MEM_rt_val),
    .MEM_ReadData     (MEM_ReadData),
    .MEM_ReadValid    (MEM_ReadValid),
    .MEM_Stall        (MEM_Stall),
    .MEM_Misaligned   (MEM_Misaligned),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_be          (dmem_be),
    .dmem_we          (dmem_we),
    .dmem_re          (dmem_re),
    .dmem_rdata       (dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic smp();
    @(negedge Clk);
  endtask

  task automatic op(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                    input logic uns, input logic [1:0] sel, input logic [31:0] addr,
                    input logic [31:0] data);
    EX_MEM_Valid     = v;
    EX_MEM_MemRead   = rd;
    EX_MEM_MemWrite  = wr;
    EX_MEM_Size      = sz;
    EX_MEM_Unsigned  = uns;
    EX_MEM_BufSel    = sel;
    EX_MEM_ALUResult = addr;
    EX_MEM_rt_val    = data;
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  // Buffer load: no stall, result and valid in the following cycle.
  task automatic buf_load_chk(input string tag, input logic [1:0] sel,
                              input logic [31:0] idx, input logic [31:0] exp);
    cyc(); op(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, sel, idx, 32'h0);
    smp();
    chk({tag, ".stall"}, MEM_Stall, 1'b0);
    chk({tag, ".re"}, dmem_re, 1'b0);
    cyc(); idle();
    smp();
    chk({tag, ".valid"}, MEM_ReadValid, 1'b1);
    chk({tag, ".data"}, MEM_ReadData, exp);
  endtask

  // Memory load with latency 3: stall in accept cycle and two WAIT cycles,
  // result one cycle after the stall drops.
  task automatic mem_load_chk(input string tag, input logic [31:0] addr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] rdata,
                              input logic [31:0] exp);
    cyc(); op(1'b1, 1'b1, 1'b0, sz, uns, 2'b00, addr, 32'h0);
    dmem_rdata = rdata;
    smp();
    chk({tag, ".stall0"}, MEM_Stall, 1'b1);
    chk({tag, ".re0"}, dmem_re, 1'b1);
    chk({tag, ".addr0"}, dmem_addr, addr);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      smp();
      chk($sformatf("%s.stall%0d", tag, k), MEM_Stall, (k < 3) ? 1'b1 : 1'b0);
      chk($sformatf("%s.valid%0d", tag, k), MEM_ReadValid, 1'b0);
      if (k == 1) begin
        chk({tag, ".re1"}, dmem_re, 1'b0);
        chk({tag, ".addr_hold"}, dmem_addr, addr);
      end
    end
    cyc(); idle();
    smp();
    chk({tag, ".valid"}, MEM_ReadValid, 1'b1);
    chk({tag, ".data"}, MEM_ReadData, exp);
    cyc();
    smp();
    chk({tag, ".pulse"}, MEM_ReadValid, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    dmem_rdata = 32'h0;
    idle();
    cyc();
    smp();
    chk("rst.data", MEM_ReadData, 32'h0);
    chk("rst.valid", MEM_ReadValid, 1'b0);
    chk("rst.stall", MEM_Stall, 1'b0);
    chk("rst.mis", MEM_Misaligned, 1'b0);
    cyc(); Reset = 1'b0;

    // Buffer channel 1 store then immediate load of the same word.
    cyc(); op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 2'b10, 32'h5, 32'hDEADBEEF);
    smp();
    chk("bst.stall", MEM_Stall, 1'b0);
    chk("bst.we", dmem_we, 1'b0);
    buf_load_chk("bld1", 2'b10, 32'h5, 32'hDEADBEEF);
    buf_load_chk("bld0", 2'b01, 32'h5, 32'h0);

    // Byte loads at lane 3, signed then unsigned.
    mem_load_chk("lbs", 32'h103, SZ_BYTE, 1'b0, 32'h80FF0011, 32'hFFFFFF80);
    mem_load_chk("lbu", 32'h103, SZ_BYTE, 1'b1, 32'h80FF0011, 32'h00000080);
    mem_load_chk("lhs", 32'h102, SZ_HALF, 1'b0, 32'h80FF0011, 32'hFFFF80FF);

    // Half store to the upper lanes.
    cyc(); op(1'b1, 1'b0, 1'b1, SZ_HALF, 1'b0, 2'b00, 32'h202, 32'h0000ABCD);
    smp();
    chk("sh.be", dmem_be, 4'b1100);
    chk("sh.wdata", dmem_wdata, 32'hABCDABCD);
    chk("sh.we", dmem_we, 1'b1);
    chk("sh.addr", dmem_addr, 32'h202);
    chk("sh.stall", MEM_Stall, 1'b0);
    cyc(); op(1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b0, 2'b00, 32'h201, 32'h000000A5);
    smp();
    chk("sb.be", dmem_be, 4'b0010);
    chk("sb.wdata", dmem_wdata, 32'hA5A5A5A5);
    cyc(); idle();
    smp();
    chk("sh.we_off", dmem_we, 1'b0);

    // Misaligned word load is suppressed and faults one cycle later.
    cyc(); op(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 2'b00, 32'h102, 32'h0);
    smp();
    chk("mis.re", dmem_re, 1'b0);
    chk("mis.stall", MEM_Stall, 1'b0);
    chk("mis.early", MEM_Misaligned, 1'b0);
    cyc(); op(1'b1, 1'b0, 1'b1, SZ_HALF, 1'b0, 2'b00, 32'h201, 32'h1111);
    smp();
    chk("mis.pulse", MEM_Misaligned, 1'b1);
    chk("mis.valid", MEM_ReadValid, 1'b0);
    chk("mish.we", dmem_we, 1'b0);
    cyc(); idle();
    smp();
    chk("mish.pulse", MEM_Misaligned, 1'b1);
    cyc();
    smp();
    chk("mis.clear", MEM_Misaligned, 1'b0);
    mem_load_chk("lw", 32'h104, SZ_WORD, 1'b0, 32'h12345678, 32'h12345678);

    // Multiple select bits: lowest channel wins.
    cyc(); op(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 2'b11, 32'h2, 32'h1234);
    buf_load_chk("sel.ch0", 2'b01, 32'h2, 32'h1234);
    buf_load_chk("sel.ch1", 2'b10, 32'h2, 32'h0);

    // Read and write together: store only.
    cyc(); op(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 2'b10, 32'h3, 32'h5555);
    smp();
    chk("rw.stall", MEM_Stall, 1'b0);
    cyc(); op(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 2'b00, 32'h300, 32'h7777);
    smp();
    chk("rw.valid", MEM_ReadValid, 1'b0);
    chk("rwm.we", dmem_we, 1'b1);
    chk("rwm.re", dmem_re, 1'b0);
    chk("rwm.stall", MEM_Stall, 1'b0);
    buf_load_chk("rw.buf", 2'b10, 32'h3, 32'h5555);

    // Reset in the second WAIT cycle of a memory load.
    cyc(); op(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 2'b00, 32'h100, 32'h0);
    dmem_rdata = 32'hCAFEF00D;
    smp();
    chk("rw2.stall0", MEM_Stall, 1'b1);
    cyc();
    smp();
    chk("rw2.stall1", MEM_Stall, 1'b1);
    cyc(); Reset = 1'b1;
    #1;
    chk("arst.stall", MEM_Stall, 1'b0);
    chk("arst.re", dmem_re, 1'b0);
    chk("arst.addr", dmem_addr, 32'h0);
    chk("arst.data", MEM_ReadData, 32'h0);
    chk("arst.valid", MEM_ReadValid, 1'b0);
    chk("arst.mis", MEM_Misaligned, 1'b0);
    cyc(); Reset = 1'b0; idle();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk($sformatf("arst.novalid%0d", k), MEM_ReadValid, 1'b0);
      cyc();
    end
    buf_load_chk("arst.buf0", 2'b01, 32'h2, 32'h0);
    buf_load_chk("arst.buf1", 2'b10, 32'h5, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
